// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, result-source selects and the
// packed control bundle carried from ID into EX.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic       reg_wr;
    logic [1:0] result_src;
    logic       mem_wr;
    logic       jump;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       jalr;
    logic       zero_cond;
    logic [3:0] byte_sel;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OP_OP || opc == OP_STORE || opc == OP_BRANCH);
  endfunction

endpackage

// File: rtl/riscv_ctrl_i.sv
// Main control decoder: maps an RV32I instruction onto the ctrl_t bundle.
module riscv_ctrl_i
  import riscv_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t      c;
  logic [2:0] f3;
  logic       f7b5;

  assign f3   = instr[14:12];
  assign f7b5 = instr[30];
  assign ctrl = c;

  always_comb begin
    c = '0;
    unique case (f3[1:0])
      2'b00:   c.byte_sel = 4'b0001;
      2'b01:   c.byte_sel = 4'b0011;
      default: c.byte_sel = 4'b1111;
    endcase
    case (instr[6:0])
      OP_LUI:    begin c.reg_wr = 1'b1; c.alu_src_b = 1'b1; c.alu_ctrl = 4'b1111; end
      OP_AUIPC:  begin c.reg_wr = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 1'b1; end
      OP_JAL:    begin c.reg_wr = 1'b1; c.result_src = RES_PC4; c.jump = 1'b1; end
      OP_JALR: begin
        c.reg_wr = 1'b1; c.result_src = RES_PC4; c.jump = 1'b1;
        c.jalr = 1'b1; c.alu_src_b = 1'b1;
      end
      OP_BRANCH: begin
        // Ordered compares reuse SLT/SLTU; zero_cond picks which ALU flag takes the branch.
        c.branch    = 1'b1;
        c.alu_ctrl  = f3[2] ? {2'b00, 1'b1, f3[1]} : 4'b1000;
        c.zero_cond = f3[2] ^ ~f3[0];
      end
      OP_LOAD:   begin c.reg_wr = 1'b1; c.result_src = RES_MEM; c.alu_src_b = 1'b1; end
      OP_STORE:  begin c.mem_wr = 1'b1; c.alu_src_b = 1'b1; end
      OP_OPIMM:  begin c.reg_wr = 1'b1; c.alu_src_b = 1'b1; c.alu_ctrl = {f3 == 3'b101 && f7b5, f3}; end
      OP_OP:     begin c.reg_wr = 1'b1; c.alu_ctrl = {f7b5, f3}; end
      default:   c = '0;
    endcase
  end

endmodule

// File: rtl/riscv_immext.sv
// Immediate extractor: sign-extended I/S/B/U/J immediate selected by opcode.
module riscv_immext
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'b0};
      OP_JAL:    imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_regfile_byp.sv
// Reset-cleared register file with write-first bypass; x0 and indices >= NREG
// are never stored.
module riscv_regfile_byp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic            we,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_live;
  logic            wr_ok;

  assign wr_live = we && (wa != '0);
  assign wr_ok   = wr_live && (32'(wa) < NREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa[AW-1:0]] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (wr_live && wa == ra1)   rd1 = wd;
    else if (32'(ra1) < NREG)   rd1 = regs[ra1[AW-1:0]];
    if (wr_live && wa == ra2)   rd2 = wd;
    else if (32'(ra2) < NREG)   rd2 = regs[ra2[AW-1:0]];
  end

endmodule

// File: rtl/riscv_decode_hzd.sv
// Decode stage: control/immediate decode, bypassed register read, load-use
// hazard detection and the ID/EX pipeline register.
module riscv_decode_hzd
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [31:0]       i_instr_d,
  input  logic              i_valid_d,
  input  logic [XLEN-1:0]   i_pc_d,
  input  logic [XLEN-1:0]   i_pc_plus_4d,
  input  logic [4:0]        i_rd_w,
  input  logic [XLEN-1:0]   i_result_w,
  input  logic              i_reg_write_w,
  input  logic              i_pc_src_e,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_flush_d,
  output logic              o_valid_e,
  output logic [CTRL_W-1:0] o_ctrl_e,
  output logic [XLEN-1:0]   o_rd1_e,
  output logic [XLEN-1:0]   o_rd2_e,
  output logic [XLEN-1:0]   o_imm_e,
  output logic [XLEN-1:0]   o_pc_e,
  output logic [XLEN-1:0]   o_pc_plus_4e,
  output logic [4:0]        o_rs1_e,
  output logic [4:0]        o_rs2_e,
  output logic [4:0]        o_rd_e,
  output logic [2:0]        o_funct3_e,
  output logic              o_illegal_e
);

  logic [CTRL_W-1:0] ctrl_d;
  ctrl_t             ctrl_dec;
  ctrl_t             ctrl_e;
  logic [31:0]       imm_d;
  logic [XLEN-1:0]   rd1_d, rd2_d;
  logic [4:0]        rs1_d, rs2_d, rd_d;
  logic              use_rs1, use_rs2, illegal_d;
  logic              lwstall, flush_e;

  assign rs1_d    = i_instr_d[19:15];
  assign rs2_d    = i_instr_d[24:20];
  assign rd_d     = i_instr_d[11:7];
  assign use_rs1  = uses_rs1(i_instr_d[6:0]);
  assign use_rs2  = uses_rs2(i_instr_d[6:0]);
  assign ctrl_dec = ctrl_t'(ctrl_d);
  assign ctrl_e   = ctrl_t'(o_ctrl_e);

  riscv_ctrl_i u_ctrl (.instr(i_instr_d), .ctrl(ctrl_d));
  riscv_immext u_imm  (.instr(i_instr_d), .imm(imm_d));

  riscv_regfile_byp #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk(i_clk), .rst_n(i_rstn),
    .ra1(rs1_d), .ra2(rs2_d),
    .wa(i_rd_w), .wd(i_result_w), .we(i_reg_write_w),
    .rd1(rd1_d), .rd2(rd2_d)
  );

  assign illegal_d = (use_rs1 && 32'(rs1_d) >= NREG) ||
                     (use_rs2 && 32'(rs2_d) >= NREG) ||
                     (ctrl_dec.reg_wr && 32'(rd_d) >= NREG);

  // Gating on o_valid_e lets an async reset drop the stall in the same cycle.
  assign lwstall = o_valid_e && (ctrl_e.result_src == RES_MEM) && (o_rd_e != '0) &&
                   ((use_rs1 && o_rd_e == rs1_d) || (use_rs2 && o_rd_e == rs2_d)) &&
                   i_valid_d;

  assign o_stall_f = lwstall && !i_pc_src_e;
  assign o_stall_d = lwstall && !i_pc_src_e;
  assign o_flush_d = i_pc_src_e;
  assign flush_e   = lwstall || i_pc_src_e;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn || flush_e) begin
      o_valid_e    <= 1'b0;
      o_ctrl_e     <= '0;
      o_rd1_e      <= '0;
      o_rd2_e      <= '0;
      o_imm_e      <= '0;
      o_pc_e       <= '0;
      o_pc_plus_4e <= '0;
      o_rs1_e      <= '0;
      o_rs2_e      <= '0;
      o_rd_e       <= '0;
      o_funct3_e   <= '0;
      o_illegal_e  <= 1'b0;
    end else begin
      o_valid_e    <= i_valid_d;
      o_ctrl_e     <= ctrl_d;
      o_rd1_e      <= rd1_d;
      o_rd2_e      <= rd2_d;
      o_imm_e      <= XLEN'(imm_d);
      o_pc_e       <= i_pc_d;
      o_pc_plus_4e <= i_pc_plus_4d;
      o_rs1_e      <= rs1_d;
      o_rs2_e      <= rs2_d;
      o_rd_e       <= rd_d;
      o_funct3_e   <= i_instr_d[14:12];
      o_illegal_e  <= i_valid_d && illegal_d;
    end
  end

endmodule

// File: tb/tb_riscv_decode_hzd.sv
// Bench for riscv_decode_hzd: RV32I and RV32E instances driven in parallel,
// checked against a register-array/hazard model built from the ISA rules.
module tb_riscv_decode_hzd;
  import riscv_pkg::*;

  logic        i_clk, i_rstn, i_valid_d, i_reg_write_w, i_pc_src_e;
  logic [31:0] i_instr_d, i_pc_d, i_pc_plus_4d, i_result_w;
  logic [4:0]  i_rd_w;

  logic              a_stall_f, a_stall_d, a_flush_d, a_valid_e, a_illegal_e;
  logic [CTRL_W-1:0] a_ctrl_e;
  logic [31:0]       a_rd1_e, a_rd2_e, a_imm_e, a_pc_e, a_pc4_e;
  logic [4:0]        a_rs1_e, a_rs2_e, a_rd_e;
  logic [2:0]        a_funct3_e;
  logic              b_stall_f, b_stall_d, b_flush_d, b_valid_e, b_illegal_e;
  logic [CTRL_W-1:0] b_ctrl_e;
  logic [31:0]       b_rd1_e, b_rd2_e, b_imm_e, b_pc_e, b_pc4_e;
  logic [4:0]        b_rs1_e, b_rs2_e, b_rd_e;
  logic [2:0]        b_funct3_e;

  riscv_decode_hzd #(.XLEN(32), .NREG(32)) dut_i (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_instr_d(i_instr_d), .i_valid_d(i_valid_d),
    .i_pc_d(i_pc_d), .i_pc_plus_4d(i_pc_plus_4d), .i_rd_w(i_rd_w), .i_result_w(i_result_w),
    .i_reg_write_w(i_reg_write_w), .i_pc_src_e(i_pc_src_e),
    .o_stall_f(a_stall_f), .o_stall_d(a_stall_d), .o_flush_d(a_flush_d), .o_valid_e(a_valid_e),
    .o_ctrl_e(a_ctrl_e), .o_rd1_e(a_rd1_e), .o_rd2_e(a_rd2_e), .o_imm_e(a_imm_e),
    .o_pc_e(a_pc_e), .o_pc_plus_4e(a_pc4_e), .o_rs1_e(a_rs1_e), .o_rs2_e(a_rs2_e),
    .o_rd_e(a_rd_e), .o_funct3_e(a_funct3_e), .o_illegal_e(a_illegal_e));

  riscv_decode_hzd #(.XLEN(32), .NREG(16)) dut_e (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_instr_d(i_instr_d), .i_valid_d(i_valid_d),
    .i_pc_d(i_pc_d), .i_pc_plus_4d(i_pc_plus_4d), .i_rd_w(i_rd_w), .i_result_w(i_result_w),
    .i_reg_write_w(i_reg_write_w), .i_pc_src_e(i_pc_src_e),
    .o_stall_f(b_stall_f), .o_stall_d(b_stall_d), .o_flush_d(b_flush_d), .o_valid_e(b_valid_e),
    .o_ctrl_e(b_ctrl_e), .o_rd1_e(b_rd1_e), .o_rd2_e(b_rd2_e), .o_imm_e(b_imm_e),
    .o_pc_e(b_pc_e), .o_pc_plus_4e(b_pc4_e), .o_rs1_e(b_rs1_e), .o_rs2_e(b_rs2_e),
    .o_rd_e(b_rd_e), .o_funct3_e(b_funct3_e), .o_illegal_e(b_illegal_e));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: architectural registers per variant and the load in EX.
  logic [31:0] rfi [32];
  logic [31:0] rfe [16];
  logic        m_valid, m_load;
  logic [4:0]  m_rd;

  logic [6:0] opcs [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                           OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {7'b0, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [11:0] s;
    logic [12:0] b;
    logic [20:0] j;
    s = {ins[31:25], ins[11:7]};
    b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR: return 32'($signed(ins[31:20]));
      OP_STORE:         return 32'($signed(s));
      OP_BRANCH:        return 32'($signed(b));
      OP_LUI, OP_AUIPC: return ins & 32'hFFFF_F000;
      OP_JAL:           return 32'($signed(j));
      default:          return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(input bit e, input logic [4:0] idx, input logic rw,
                                          input logic [4:0] rdw, input logic [31:0] resw);
    if (rw && rdw != 5'd0 && rdw == idx) return resw;
    if (idx == 5'd0) return 32'd0;
    if (e) return (idx < 5'd16) ? rfe[idx[3:0]] : 32'd0;
    return rfi[idx];
  endfunction

  function automatic logic [22:0] pack(input logic v, input logic [CTRL_W-1:0] cw,
                                       input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [4:0] rd, input logic [2:0] f3);
    ctrl_t c;
    c = ctrl_t'(cw);
    return {v, c.reg_wr, c.result_src, c.mem_wr, r1, r2, rd, f3};
  endfunction

  task automatic ex_check(input string p, input logic [22:0] so, input logic [22:0] sx,
                          input logic [31:0] r1o, input logic [31:0] r1x,
                          input logic [31:0] r2o, input logic [31:0] r2x,
                          input logic [31:0] imo, input logic [31:0] imx,
                          input logic [31:0] pco, input logic [31:0] pcx,
                          input logic [31:0] p4o, input logic [31:0] p4x,
                          input logic ilo, input logic ilx,
                          input logic [CTRL_W-1:0] co, input logic bub);
    check({p, "_fields"}, 64'(so), 64'(sx));
    check({p, "_rd1"}, 64'(r1o), 64'(r1x));
    check({p, "_rd2"}, 64'(r2o), 64'(r2x));
    check({p, "_imm"}, 64'(imo), 64'(imx));
    check({p, "_pc"}, 64'(pco), 64'(pcx));
    check({p, "_pc4"}, 64'(p4o), 64'(p4x));
    check({p, "_illegal"}, 64'(ilo), 64'(ilx));
    if (bub) check({p, "_bubble_ctrl"}, 64'(co), 64'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rfi[i] = 32'd0;
    for (int i = 0; i < 16; i++) rfe[i] = 32'd0;
    m_valid = 1'b0;
    m_load  = 1'b0;
    m_rd    = 5'd0;
  endtask

  // One ID cycle: drive, check hazard outputs, clock, check the EX register.
  task automatic step(input logic [31:0] ins, input logic v, input logic rw,
                      input logic [4:0] rdw, input logic [31:0] resw, input logic ps,
                      output logic stalled);
    logic [6:0]  opc;
    logic [4:0]  s1, s2, d;
    logic        u1, u2, wr, lw, bub, ill_e;
    logic [1:0]  rs;
    logic [22:0] sx;
    logic [31:0] pc, imm, a1, a2, e1, e2;
    pc = $urandom;
    i_instr_d = ins; i_valid_d = v; i_pc_d = pc; i_pc_plus_4d = pc + 32'd4;
    i_reg_write_w = rw; i_rd_w = rdw; i_result_w = resw; i_pc_src_e = ps;
    opc = ins[6:0]; s1 = ins[19:15]; s2 = ins[24:20]; d = ins[11:7];
    u1  = !(opc inside {OP_LUI, OP_AUIPC, OP_JAL});
    u2  = opc inside {OP_OP, OP_STORE, OP_BRANCH};
    wr  = opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP};
    rs  = (opc == OP_LOAD) ? RES_MEM : (opc inside {OP_JAL, OP_JALR}) ? RES_PC4 : RES_ALU;
    lw  = m_valid && m_load && m_rd != 5'd0 && ((u1 && m_rd == s1) || (u2 && m_rd == s2)) && v;
    bub = lw || ps;
    imm = ref_imm(ins);
    a1 = rf_read(0, s1, rw, rdw, resw); a2 = rf_read(0, s2, rw, rdw, resw);
    e1 = rf_read(1, s1, rw, rdw, resw); e2 = rf_read(1, s2, rw, rdw, resw);
    ill_e = v && ((u1 && s1 >= 5'd16) || (u2 && s2 >= 5'd16) || (wr && d >= 5'd16));
    sx = bub ? 23'd0 : {v, wr, rs, opc == OP_STORE, s1, s2, d, ins[14:12]};
    #1;
    check("stall_f", 64'(a_stall_f), 64'(lw && !ps));
    check("stall_d", 64'(a_stall_d), 64'(lw && !ps));
    check("flush_d", 64'(a_flush_d), 64'(ps));
    check("e_stall_d", 64'(b_stall_d), 64'(lw && !ps));
    @(posedge i_clk);
    if (rw && rdw != 5'd0) begin
      rfi[rdw] = resw;
      if (rdw < 5'd16) rfe[rdw[3:0]] = resw;
    end
    m_valid = !bub && v;
    m_load  = !bub && opc == OP_LOAD;
    m_rd    = bub ? 5'd0 : d;
    #1;
    ex_check("i", pack(a_valid_e, a_ctrl_e, a_rs1_e, a_rs2_e, a_rd_e, a_funct3_e), sx,
             a_rd1_e, bub ? 32'd0 : a1, a_rd2_e, bub ? 32'd0 : a2, a_imm_e, bub ? 32'd0 : imm,
             a_pc_e, bub ? 32'd0 : pc, a_pc4_e, bub ? 32'd0 : pc + 32'd4,
             a_illegal_e, 1'b0, a_ctrl_e, bub);
    ex_check("e", pack(b_valid_e, b_ctrl_e, b_rs1_e, b_rs2_e, b_rd_e, b_funct3_e), sx,
             b_rd1_e, bub ? 32'd0 : e1, b_rd2_e, bub ? 32'd0 : e2, b_imm_e, bub ? 32'd0 : imm,
             b_pc_e, bub ? 32'd0 : pc, b_pc4_e, bub ? 32'd0 : pc + 32'd4,
             b_illegal_e, !bub && ill_e, b_ctrl_e, bub);
    stalled = lw && !ps;
  endtask

  task automatic dump_regs();
    logic st;
    for (int i = 0; i < 32; i++)
      step(enc_r(5'(31 - i), 5'(i), 3'd0, 5'd0, OP_OP), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
  endtask

  initial begin
    logic        st;
    logic [31:0] ins, r;
    logic [31:0] lw5, add6;
    lw5  = enc_i(12'd0, 5'd1, 3'd2, 5'd5, OP_LOAD);
    add6 = enc_r(5'd2, 5'd5, 3'd0, 5'd6, OP_OP);

    // Reset with random inputs, including attempted write-backs.
    model_reset();
    i_rstn = 1'b0;
    i_instr_d = $urandom; i_valid_d = 1'b1; i_pc_d = $urandom; i_pc_plus_4d = $urandom;
    i_rd_w = 5'd5; i_result_w = $urandom; i_reg_write_w = 1'b1; i_pc_src_e = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      ex_check("rst_i", pack(a_valid_e, a_ctrl_e, a_rs1_e, a_rs2_e, a_rd_e, a_funct3_e), 23'd0,
               a_rd1_e, 32'd0, a_rd2_e, 32'd0, a_imm_e, 32'd0, a_pc_e, 32'd0, a_pc4_e, 32'd0,
               a_illegal_e, 1'b0, a_ctrl_e, 1'b1);
      ex_check("rst_e", pack(b_valid_e, b_ctrl_e, b_rs1_e, b_rs2_e, b_rd_e, b_funct3_e), 23'd0,
               b_rd1_e, 32'd0, b_rd2_e, 32'd0, b_imm_e, 32'd0, b_pc_e, 32'd0, b_pc4_e, 32'd0,
               b_illegal_e, 1'b0, b_ctrl_e, 1'b1);
      check("rst_stall", 64'(a_stall_d), 64'd0);
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_rstn = 1'b1;

    step(enc_r(5'd0, 5'd5, 3'd0, 5'd1, OP_OP), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    check("post_rst_x5", 64'(a_rd1_e), 64'd0);

    // Write-back bypass into the instruction being decoded.
    step(enc_r(5'd0, 5'd3, 3'd0, 5'd4, OP_OP), 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, st);
    check("bypass_rd1", 64'(a_rd1_e), 64'hDEADBEEF);
    step(enc_r(5'd0, 5'd3, 3'd0, 5'd4, OP_OP), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);

    // Load-use: one bubble, then the dependent add proceeds.
    step(lw5, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    step(add6, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    check("lu_bubble_valid", 64'(a_valid_e), 64'd0);
    step(add6, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    check("lu_rs1", 64'(a_rs1_e), 64'd5);
    check("lu_valid", 64'(a_valid_e), 64'd1);
    step(lw5, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    step({20'h12345, 5'd5, OP_LUI}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);

    // Redirect coinciding with a load-use hazard.
    step(lw5, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    step(add6, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, st);
    check("redir_valid", 64'(a_valid_e), 64'd0);

    // RV32E index limits.
    step(enc_i(12'd1, 5'd0, 3'd0, 5'd17, OP_OPIMM), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    check("rv32e_illegal", 64'(b_illegal_e), 64'd1);
    step(enc_i(12'd0, 5'd0, 3'd0, 5'd0, OP_OPIMM), 1'b1, 1'b1, 5'd20, 32'hCAFEF00D, 1'b0, st);
    dump_regs();

    // x0 stays zero whether or not the bypass path is live.
    step(enc_r(5'd0, 5'd0, 3'd0, 5'd1, OP_OP), 1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, st);
    check("x0_bypass", 64'(a_rd1_e), 64'd0);
    step(enc_r(5'd0, 5'd0, 3'd0, 5'd1, OP_OP), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    check("x0_array", 64'(a_rd1_e), 64'd0);

    // Reset arriving mid-stall.
    step(lw5, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    i_instr_d = add6; i_valid_d = 1'b1; i_reg_write_w = 1'b0; i_pc_src_e = 1'b0;
    #1;
    check("mr_stall", 64'(a_stall_d), 64'd1);
    i_rstn = 1'b0;
    #1;
    check("mr_stall_drop", 64'(a_stall_d), 64'd0);
    check("mr_e_stall_drop", 64'(b_stall_f), 64'd0);
    check("mr_valid", 64'(a_valid_e), 64'd0);
    check("mr_rd", 64'(a_rd_e), 64'd0);
    model_reset();
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Random traffic; a stalled instruction is re-presented as IF/ID would.
    st = 1'b0;
    ins = 32'd0;
    for (int k = 0; k < 300; k++) begin
      if (!st) begin
        r = $urandom;
        r[6:0] = opcs[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) == 1) begin
          r[19:15] = 5'($urandom_range(0, 7));
          r[24:20] = 5'($urandom_range(0, 7));
          r[11:7]  = 5'($urandom_range(0, 7));
        end
        ins = r;
      end
      step(ins, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31)),
           $urandom, $urandom_range(0, 9) == 0, st);
    end
    step(enc_i(12'd0, 5'd0, 3'd0, 5'd0, OP_OPIMM), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    dump_regs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_decode_hzd.md
# riscv_decode_hzd

Parametrised pipelined decode stage: decodes the ID-stage instruction, reads a reset-cleared register file with write-back bypass, detects load-use hazards, and holds the ID/EX pipeline register with stall, flush and valid tracking. Sits between the IF/ID register and the execute stage of the pipelined core. It replaces the previous decode stage, which had no stall, no valid bit and no hazard logic. Supports RV32I (32 registers) and RV32E (16 registers, with an illegal-register flag).

## Interface
- XLEN, 32, datapath width
- NREG, 32, architectural register count; 32 (RV32I) or 16 (RV32E)
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_instr_d  in  32  instruction in ID
- i_valid_d  in  1  ID slot holds a real instruction
- i_pc_d / i_pc_plus_4d  in  XLEN  PC and PC+4 of the ID instruction
- i_rd_w  in  5  write-back destination
- i_result_w  in  XLEN  write-back data
- i_reg_write_w  in  1  write-back enable
- i_pc_src_e  in  1  EX redirect (taken branch or jump)
- o_stall_f / o_stall_d  out  1  hold the PC and IF/ID register
- o_flush_d  out  1  clear the IF/ID register
- o_valid_e  out  1  EX slot valid
- o_ctrl_e  out  CTRL_W  packed control bundle (reg_wr, result_src[1:0], mem_wr, jump, branch, alu_ctrl[3:0], alu_src_a, alu_src_b, jalr, zero_cond, byte_sel[3:0])
- o_rd1_e / o_rd2_e  out  XLEN  operand data
- o_imm_e / o_pc_e / o_pc_plus_4e  out  XLEN  immediate, PC, PC+4
- o_rs1_e / o_rs2_e / o_rd_e  out  5  register indices
- o_funct3_e  out  3  funct3
- o_illegal_e  out  1  register index ≥ NREG

## Operation
- Decode: control comes from riscv_ctrl_i; the immediate comes from riscv_immext.
- Register file:
  - NREG×XLEN entries; x0 reads 0 and ignores writes.
  - Written on the rising clock edge when i_reg_write_w is high and i_rd_w is non-zero and below NREG.
  - Reads are combinational with write-first bypass: if i_reg_write_w is high, i_rd_w is non-zero, and i_rd_w equals rsN, the read returns i_result_w.
- Operand use:
  - rs1 is used unless the opcode is LUI, AUIPC or JAL.
  - rs2 is used only for OP, STORE and BRANCH.
- Load-use hazard: lwstall is asserted when all of the following hold:
  - o_valid_e is high;
  - o_ctrl_e.result_src equals RES_MEM;
  - o_rd_e is non-zero;
  - o_rd_e matches a used rs1 or rs2 of the ID instruction;
  - i_valid_d is high.
- Outputs:
  - o_stall_f = o_stall_d = lwstall & ~i_pc_src_e
  - o_flush_d = i_pc_src_e
  - Internal flush_e = lwstall | i_pc_src_e
- ID/EX register update, in priority order:
  1. Reset: all fields 0.
  2. flush_e: bubble, meaning every field 0 including valid, reg_wr and mem_wr.
  3. Otherwise: load the decoded ID values, with valid = i_valid_d.
  - The ID/EX register never holds; a stall always inserts a bubble.
- Illegal register: o_illegal_e = valid & (any used index ≥ NREG). It is always 0 when NREG = 32. An illegal instruction still passes through; the trap is the EX stage's job.

## Timing
- Reset (asynchronous assert, synchronous release): every o_*_e output is 0, o_valid_e is 0, and all registers read 0.
- ID to EX latency: 1 cycle.
- A regfile write in cycle N is visible to an ID read in cycle N through the bypass, and from the array from cycle N+1.
- Load-use: the stall lasts exactly 1 cycle. The instruction is re-presented in ID the next cycle, when the load has moved to MEM, and lwstall drops.
- A redirect coinciding with lwstall: the redirect wins. No stall; IF/ID and ID/EX are both flushed.
- Reset asserted mid-stall: outputs clear immediately and the stall drops combinationally, because o_valid_e is now 0.
- A write to rd ≥ NREG in RV32E mode is dropped silently.

## Structure
- Package riscv_pkg holds:
  - opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP;
  - RES_ALU, RES_MEM, RES_PC4;
  - the ctrl_t packed struct and CTRL_W.
- One sub-module, riscv_regfile_byp: parametrised register file with reset and write-first bypass.
- Hazard logic and the ID/EX register live in the top level.
- riscv_ctrl_i and riscv_immext are reused unchanged.

## Test plan
- Reset: assert i_rstn = 0 with random inputs → all outputs 0. After release, reading x5 returns 0.
- Bypass: write x3 = 0xDEADBEEF in the same cycle that ID decodes `add x4,x3,x0` → o_rd1_e = 0xDEADBEEF on the next edge.
- Load-use: `lw x5,0(x1)` followed by `add x6,x5,x2` → one cycle with o_stall_d = 1 and o_valid_e = 0, then the add enters EX with o_rs1_e = 5. The sequence `lw x5` followed by `lui x5` produces no stall.
- Redirect: pulse i_pc_src_e = 1 during a load-use stall → o_stall_d = 0, o_flush_d = 1, next o_valid_e = 0.
- RV32E (NREG = 16): `addi x17,x0,1` → o_illegal_e = 1. A write-back to x20 leaves every register unchanged.
- x0: write-back to x0 with 0x1234 → a read of x0 still returns 0, with and without the bypass path.
